// File: rtl/seq_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one iteration per clock.
// Optional two's-complement input handling is enabled by defining SEQ_BCD_SIGNED_EN.
module seq_bcd_converter #(
   parameter int WIDTH  = 9,
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [WIDTH-1:0]    value,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd,
`ifdef SEQ_BCD_SIGNED_EN
   output logic                sign,
`endif
   output logic                overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Add 3 to every digit above 4 so the following left shift carries correctly.
   function automatic logic [BW-1:0] f_add3(input logic [BW-1:0] d);
      logic [BW-1:0] r;
      r = d;
      for (int k = 0; k < DIGITS; k++) begin
         if (d[4*k +: 4] > 4'd4) begin
            r[4*k +: 4] = d[4*k +: 4] + 4'd3;
         end else begin
            r[4*k +: 4] = d[4*k +: 4];
         end
      end
      return r;
   endfunction

`ifdef SEQ_BCD_SIGNED_EN
   // Magnitude as a WIDTH-bit unsigned value, so the most negative input maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] f_magnitude(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] m;
      if (v[WIDTH-1]) begin
         m = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         m = v;
      end
      return m;
   endfunction
`endif

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] r_op, w_op_nxt;
   logic [BW-1:0]    r_work, w_work_nxt;
   logic             r_ovf_work, w_ovf_work_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic [BW-1:0]    r_bcd, w_bcd_nxt;
   logic             r_ovf, w_ovf_nxt;
   logic [BW-1:0]    w_adj;
   logic [BW-1:0]    w_shift_work;
   logic             w_shift_ovf;
   logic [WIDTH-1:0] w_accept_op;
`ifdef SEQ_BCD_SIGNED_EN
   logic             r_sign_work, w_sign_work_nxt;
   logic             r_sign, w_sign_nxt;
`endif

`ifdef SEQ_BCD_SIGNED_EN
   assign w_accept_op = f_magnitude(value);
`else
   assign w_accept_op = value;
`endif

   assign w_adj        = f_add3(r_work);
   assign w_shift_work = {w_adj[BW-2:0], r_op[WIDTH-1]};
   assign w_shift_ovf  = r_ovf_work | w_adj[BW-1];

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_op_nxt       = r_op;
      w_work_nxt     = r_work;
      w_ovf_work_nxt = r_ovf_work;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_bcd_nxt      = r_bcd;
      w_ovf_nxt      = r_ovf;
`ifdef SEQ_BCD_SIGNED_EN
      w_sign_work_nxt = r_sign_work;
      w_sign_nxt      = r_sign;
`endif
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_state_nxt    = SHIFT;
               w_cnt_nxt      = CW'(WIDTH);
               w_op_nxt       = w_accept_op;
               w_work_nxt     = {BW{1'b0}};
               w_ovf_work_nxt = 1'b0;
               w_busy_nxt     = 1'b1;
`ifdef SEQ_BCD_SIGNED_EN
               w_sign_work_nxt = value[WIDTH-1];
`endif
            end else begin
               w_state_nxt = IDLE;
               w_busy_nxt  = 1'b0;
            end
         end
         SHIFT: begin
            w_work_nxt     = w_shift_work;
            w_op_nxt       = {r_op[WIDTH-2:0], 1'b0};
            w_ovf_work_nxt = w_shift_ovf;
            w_cnt_nxt      = r_cnt - CW'(1);
            // The final iteration's result goes straight to the output registers.
            if (r_cnt == CW'(1)) begin
               w_state_nxt = DONE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_bcd_nxt   = w_shift_work;
               w_ovf_nxt   = w_shift_ovf;
`ifdef SEQ_BCD_SIGNED_EN
               w_sign_nxt  = r_sign_work;
`endif
            end else begin
               w_state_nxt = SHIFT;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = {CW{1'b0}};
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= {CW{1'b0}};
         r_op       <= {WIDTH{1'b0}};
         r_work     <= {BW{1'b0}};
         r_ovf_work <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_bcd      <= {BW{1'b0}};
         r_ovf      <= 1'b0;
`ifdef SEQ_BCD_SIGNED_EN
         r_sign_work <= 1'b0;
         r_sign      <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_op       <= w_op_nxt;
         r_work     <= w_work_nxt;
         r_ovf_work <= w_ovf_work_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_bcd      <= w_bcd_nxt;
         r_ovf      <= w_ovf_nxt;
`ifdef SEQ_BCD_SIGNED_EN
         r_sign_work <= w_sign_work_nxt;
         r_sign      <= w_sign_nxt;
`endif
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign bcd      = r_bcd;
   assign overflow = r_ovf;
`ifdef SEQ_BCD_SIGNED_EN
   assign sign     = r_sign;
`endif

endmodule

// File: tb/tb_seq_bcd_converter.sv
// Self-checking bench for seq_bcd_converter: a 3-digit and a 2-digit instance share stimulus.
module tb_seq_bcd_converter;

   localparam int W = 9;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] value = '0;
   logic         busy3, done3, ovf3;
   logic [11:0]  bcd3;
   logic         busy2, done2, ovf2;
   logic [7:0]   bcd2;
`ifdef SEQ_BCD_SIGNED_EN
   logic         sign3, sign2;
`endif
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_bcd_converter #(.WIDTH(W), .DIGITS(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .value(value),
      .busy(busy3), .done(done3), .bcd(bcd3),
`ifdef SEQ_BCD_SIGNED_EN
      .sign(sign3),
`endif
      .overflow(ovf3)
   );

   seq_bcd_converter #(.WIDTH(W), .DIGITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .value(value),
      .busy(busy2), .done(done2), .bcd(bcd2),
`ifdef SEQ_BCD_SIGNED_EN
      .sign(sign2),
`endif
      .overflow(ovf2)
   );

   typedef struct {
      logic [8:0]  v;
      logic [11:0] e3;
      logic        eo3;
      logic [7:0]  e2;
      logic        eo2;
      logic        es;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: plain decimal arithmetic on the operand's magnitude.
   function automatic int unsigned mag_of(input logic [8:0] v);
`ifdef SEQ_BCD_SIGNED_EN
      if (v[8]) return 32'd512 - {23'd0, v};
      else return {23'd0, v};
`else
      return {23'd0, v};
`endif
   endfunction

   function automatic logic sign_of(input logic [8:0] v);
`ifdef SEQ_BCD_SIGNED_EN
      return v[8];
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [11:0] model_bcd(input int unsigned m, input int d);
      logic [11:0] r;
      int unsigned x;
      r = '0;
      x = m;
      for (int k = 0; k < d; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic model_ovf(input int unsigned m, input int d);
      int unsigned lim;
      lim = 1;
      for (int k = 0; k < d; k++) lim = lim * 10;
      return (m >= lim);
   endfunction

   task automatic launch(input logic [8:0] v);
      @(negedge clk);
      start = 1'b1;
      value = v;
   endtask

   // Follows one conversion from its accepting edge to the done cycle and checks timing and result.
   task automatic finish_conv(input string nm, input vec_t e, input bit noise,
                              input bit chain, input logic [8:0] nv);
      @(posedge clk);
      for (int c = 1; c <= W; c++) begin
         @(negedge clk);
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         value = (noise && start) ? 9'd7 : 9'($urandom);
         chk({nm, " busy"}, {60'd0, busy3, done3, busy2, done2}, 64'b1010);
      end
      @(negedge clk);
      chk({nm, " done"}, {60'd0, busy3, done3, busy2, done2}, 64'b0101);
      chk({nm, " bcd3"}, {52'd0, bcd3}, {52'd0, e.e3});
      chk({nm, " ovf3"}, {63'd0, ovf3}, {63'd0, e.eo3});
      chk({nm, " bcd2"}, {56'd0, bcd2}, {56'd0, e.e2});
      chk({nm, " ovf2"}, {63'd0, ovf2}, {63'd0, e.eo2});
`ifdef SEQ_BCD_SIGNED_EN
      chk({nm, " sign"}, {62'd0, sign3, sign2}, {62'd0, e.es, e.es});
`endif
      start = chain;
      value = chain ? nv : 9'($urandom);
      if (!chain) begin
         @(negedge clk);
         value = 9'($urandom);
         chk({nm, " idle"}, {60'd0, busy3, done3, busy2, done2}, 64'b0000);
         chk({nm, " hold"}, {44'd0, ovf3, bcd3, ovf2, bcd2}, {44'd0, e.eo3, e.e3, e.eo2, e.e2});
      end
   endtask

   function automatic vec_t model_vec(input logic [8:0] v);
      vec_t r;
      int unsigned m;
      m = mag_of(v);
      r.v   = v;
      r.e3  = model_bcd(m, 3);
      r.eo3 = model_ovf(m, 3);
      r.e2  = model_bcd(m, 2)[7:0];
      r.eo2 = model_ovf(m, 2);
      r.es  = sign_of(v);
      return r;
   endfunction

   initial begin
      vec_t e;
      logic [8:0] rv;
      logic bad;
`ifdef SEQ_BCD_SIGNED_EN
      tbl.push_back('{9'h1F6, 12'h010, 1'b0, 8'h10, 1'b0, 1'b1});
      tbl.push_back('{9'h100, 12'h256, 1'b0, 8'h56, 1'b1, 1'b1});
      tbl.push_back('{9'h0FF, 12'h255, 1'b0, 8'h55, 1'b1, 1'b0});
      tbl.push_back('{9'h1FF, 12'h001, 1'b0, 8'h01, 1'b0, 1'b1});
      tbl.push_back('{9'd99,  12'h099, 1'b0, 8'h99, 1'b0, 1'b0});
      tbl.push_back('{9'd0,   12'h000, 1'b0, 8'h00, 1'b0, 1'b0});
`else
      tbl.push_back('{9'd255, 12'h255, 1'b0, 8'h55, 1'b1, 1'b0});
      tbl.push_back('{9'd511, 12'h511, 1'b0, 8'h11, 1'b1, 1'b0});
      tbl.push_back('{9'd123, 12'h123, 1'b0, 8'h23, 1'b1, 1'b0});
      tbl.push_back('{9'd99,  12'h099, 1'b0, 8'h99, 1'b0, 1'b0});
      tbl.push_back('{9'd100, 12'h100, 1'b0, 8'h00, 1'b1, 1'b0});
      tbl.push_back('{9'd0,   12'h000, 1'b0, 8'h00, 1'b0, 1'b0});
      tbl.push_back('{9'd1,   12'h001, 1'b0, 8'h01, 1'b0, 1'b0});
      tbl.push_back('{9'd500, 12'h500, 1'b0, 8'h00, 1'b1, 1'b0});
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset", {40'd0, busy3, done3, ovf3, bcd3, busy2, done2, ovf2, bcd2}, 64'd0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         launch(tbl[i].v);
         finish_conv("table", tbl[i], 1'b0, 1'b0, 9'd0);
      end

      // Back-to-back: second start issued during the DONE cycle.
      launch(9'd511);
      finish_conv("b2b_first", model_vec(9'd511), 1'b0, 1'b1, 9'd0);
      finish_conv("b2b_second", model_vec(9'd0), 1'b0, 1'b0, 9'd0);

      // Start pulses with value=7 during busy must be ignored.
      launch(9'd200);
      finish_conv("noise", model_vec(9'd200), 1'b1, 1'b0, 9'd0);

      // Reset at iteration 5 of a later conversion: no done and all outputs cleared.
      launch(9'd321);
      @(posedge clk);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
         value = 9'($urandom);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midreset", {40'd0, busy3, done3, ovf3, bcd3, busy2, done2, ovf2, bcd2}, 64'd0);
      bad = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if ({busy3, done3, ovf3, bcd3, busy2, done2, ovf2, bcd2} != '0) bad = 1'b1;
      end
      chk("post_reset_quiet", {63'd0, bad}, 64'd0);

      for (int n = 0; n < 30; n++) begin
         rv = 9'($urandom);
         e = model_vec(rv);
         launch(rv);
         finish_conv("random", e, n[0], 1'b0, 9'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_bcd_converter.md
SEQ_BCD_CONVERTER -- requirements
Module: seq_bcd_converter

Interface
REQ-001 SHALL have parameter WIDTH, default 9: binary input width, legal range 2..32.
REQ-002 SHALL have parameter DIGITS, default 3: number of BCD output digits, legal range 1..10.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request a conversion of value.
REQ-006 SHALL have port value  input  WIDTH  binary operand, sampled only on the accepting edge.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when result registers update.
REQ-009 SHALL have port bcd  output  4*DIGITS  result; digit k occupies bcd[4k+3:4k], digit 0 = ones.
REQ-010 SHALL have port overflow  output  1  result magnitude >= 10^DIGITS; bcd holds the low DIGITS digits.
REQ-011 SHALL have port sign  output  1  negative-result flag; present only when SIGNED_EN is defined.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL accept start only when busy=0 (IDLE or DONE); on acceptance, latch value, clear the working BCD register, load the iteration counter with WIDTH, and enter SHIFT.
REQ-014 SHALL, in each SHIFT cycle, add 3 to every working digit >4, then shift {digits, operand} left by 1 and decrement the counter; that is one iteration per clock.
REQ-015 SHALL set an internal overflow flag, sticky for the current conversion, whenever a 1 is shifted out of the MSB of the top digit.
REQ-016 SHALL move from SHIFT to DONE after exactly WIDTH iterations, copy the working digits and the overflow flag to bcd/overflow, and assert done for that single cycle.
REQ-017 SHALL go from DONE to IDLE on the next edge unless start=1, which begins a new conversion directly (back-to-back).
REQ-018 SHALL assert done exactly WIDTH+1 cycles after the accepting edge; busy SHALL be high for exactly WIDTH cycles.
REQ-019 SHALL ignore start while busy=1; the conversion in flight and its operand SHALL be unaffected.
REQ-020 SHALL hold bcd, overflow and sign stable from one DONE until the next DONE; changes to value outside the accepting edge SHALL have no effect.
REQ-021 SHALL treat value as unsigned when SIGNED_EN is undefined.

Reset
REQ-022 SHALL, on any edge with rst_n=0, force state IDLE, busy=0, done=0, bcd=0, overflow=0, sign=0 and the counter to 0, taking priority over start.
REQ-023 SHALL abandon any conversion in progress when reset occurs mid-conversion; no done pulse SHALL follow, and outputs SHALL remain 0 until a subsequent conversion completes.

Configuration
REQ-024 SHALL, with SEQ_BCD_SIGNED_EN defined, treat value as two's complement: on acceptance, record sign=value[WIDTH-1] and convert the magnitude (negated value when negative, WIDTH-bit unsigned, so -2^(WIDTH-1) converts correctly); sign is updated at DONE together with bcd.
REQ-025 SHALL, without SEQ_BCD_SIGNED_EN, omit the sign port and all negation logic.

Verification
REQ-026 SHALL cover: WIDTH=9, DIGITS=3, start with value=255 -> busy for 9 cycles, done on cycle 10 after acceptance, bcd=12'h255, overflow=0.
REQ-027 SHALL cover: value=511, then back-to-back start during DONE with value=0 -> first bcd=12'h511, second bcd=12'h000, done pulses 10 cycles apart.
REQ-028 SHALL cover: DIGITS=2, value=123 -> bcd=8'h23, overflow=1; next value=99 -> bcd=8'h99, overflow=0.
REQ-029 SHALL cover: start with value=200, then start pulses with value=7 during busy, and rst_n=0 for one cycle at iteration 5 of a later conversion -> first result 12'h200; after reset all outputs 0 and no done pulse.
REQ-030 SHALL cover, with SEQ_BCD_SIGNED_EN: value=9'h1F6 -> sign=1, bcd=12'h010; value=9'h100 -> sign=1, bcd=12'h256; value=9'h0FF -> sign=0, bcd=12'h255.
